// File: rtl/pe_wide.sv
// WIDTH-bit processing element: register file, neighbour/immediate source mux,
// single-cycle logic/arith ALU and a WIDTH-cycle shift-add multiplier.
module pe_wide #(
  parameter  int WIDTH = 8,
  parameter  int NREGS = 8,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic             wen,
  input  logic [AW-1:0]    w,
  input  logic [AW-1:0]    ra,
  input  logic [AW-1:0]    rb,
  input  logic [2:0]       src,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] north,
  input  logic [WIDTH-1:0] south,
  input  logic [WIDTH-1:0] east,
  input  logic [WIDTH-1:0] west,
  input  logic [WIDTH-1:0] imm,
  output logic [WIDTH-1:0] data,
  output logic             data_valid,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, MUL} state_t;

  state_t                        state;
  logic [NREGS-1:0][WIDTH-1:0]   rf;
  logic [WIDTH-1:0]              mcand, mplier, acc, acc_next;
  logic [CW-1:0]                 cnt;
  logic [WIDTH-1:0]              mux, a, b, res;
  logic                          accept;

  assign instr_ready = (state == IDLE);
  assign accept      = instr_valid && instr_ready;
  assign a           = rf[ra];
  assign b           = rf[rb];
  assign acc_next    = mplier[0] ? acc + mcand : acc;

  always_comb begin
    mux = '0;
    case (src)
      3'd0: mux = north;
      3'd1: mux = south;
      3'd2: mux = east;
      3'd3: mux = west;
      3'd4: mux = data;
      3'd5: mux = imm;
      default: mux = '0;
    endcase
  end

  // op 6 never reaches the result register from here; the FSM owns it
  always_comb begin
    res = '0;
    case (op)
      3'd0: res = a & b;
      3'd1: res = a | b;
      3'd2: res = a ^ b;
      3'd3: res = ~a;
      3'd4: res = a + b;
      3'd5: res = a - b;
      3'd7: res = a;
      default: res = '0;
    endcase
  end

  // Operands are read combinationally above, so a same-edge write is invisible to them
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               rf    <= '0;
    else if (accept && wen) rf[w] <= mux;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      data       <= '0;
      data_valid <= 1'b0;
      zero       <= 1'b1;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      cnt        <= '0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          if (op == 3'd6) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= CW'(WIDTH - 1);
            state  <= MUL;
          end else begin
            data       <= res;
            zero       <= (res == '0);
            data_valid <= 1'b1;
          end
        end
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (cnt == '0) begin
            data       <= acc_next;
            zero       <= (acc_next == '0);
            data_valid <= 1'b1;
            state      <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_wide.sv
// Directed bench for pe_wide (WIDTH=8, NREGS=8): hand-computed expectations,
// inputs driven #1 after the rising edge, outputs sampled there too.
module tb_pe_wide;

  logic       clk, rst, instr_valid, instr_ready, wen;
  logic [2:0] w, ra, rb, src, op;
  logic [7:0] north, south, east, west, imm, data;
  logic       data_valid, zero;

  int total  = 0;
  int passed = 0;
  int pulses;

  pe_wide #(.WIDTH(8), .NREGS(8)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .wen(wen), .w(w), .ra(ra), .rb(rb), .src(src), .op(op),
    .north(north), .south(south), .east(east), .west(west), .imm(imm),
    .data(data), .data_valid(data_valid), .zero(zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // present one instruction for one edge, then withdraw it
  task automatic issue(input logic we, input logic [2:0] wa, input logic [2:0] s,
                       input logic [2:0] o, input logic [2:0] a, input logic [2:0] b);
    wen = we; w = wa; src = s; op = o; ra = a; rb = b;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; wen = 1'b0;
    w = '0; ra = '0; rb = '0; src = '0; op = '0;
    north = 8'h21; south = 8'h00; east = 8'h00; west = 8'h00; imm = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_data", data, 8'h00);
    chk("reset_dv", data_valid, 1'b0);
    chk("reset_zero", zero, 1'b1);
    rst = 1'b0;
    chk("reset_ready", instr_ready, 1'b1);

    // neighbour write then ADD
    issue(1'b1, 3'd1, 3'd0, 3'd7, 3'd0, 3'd0);
    imm = 8'h0F;
    issue(1'b1, 3'd2, 3'd5, 3'd7, 3'd0, 3'd0);
    issue(1'b0, 3'd0, 3'd0, 3'd4, 3'd1, 3'd2);
    chk("add_data", data, 8'h30);
    chk("add_dv", data_valid, 1'b1);
    chk("add_zero", zero, 1'b0);
    @(posedge clk); #1;
    chk("add_dv_drop", data_valid, 1'b0);
    chk("add_hold", data, 8'h30);

    // feedback streaming: rf6 starts 0, data 30
    wen = 1'b1; w = 3'd6; src = 3'd4; op = 3'd7; ra = 3'd6; instr_valid = 1'b1;
    @(posedge clk); #1;
    chk("stream1_data", data, 8'h00);
    chk("stream1_dv", data_valid, 1'b1);
    @(posedge clk); #1;
    chk("stream2_data", data, 8'h30);
    chk("stream2_dv", data_valid, 1'b1);
    @(posedge clk); #1;
    chk("stream3_data", data, 8'h00);
    chk("stream3_dv", data_valid, 1'b1);
    instr_valid = 1'b0;
    @(posedge clk); #1;
    chk("stream_dv_drop", data_valid, 1'b0);

    // read-before-write
    imm = 8'h05;
    issue(1'b1, 3'd3, 3'd5, 3'd7, 3'd0, 3'd0);
    imm = 8'hAA;
    issue(1'b1, 3'd3, 3'd5, 3'd7, 3'd3, 3'd0);
    chk("rbw_old", data, 8'h05);
    issue(1'b0, 3'd0, 3'd0, 3'd7, 3'd3, 3'd0);
    chk("rbw_new", data, 8'hAA);

    // wrap / zero flag and logic ops
    imm = 8'hFF;
    issue(1'b1, 3'd0, 3'd5, 3'd7, 3'd0, 3'd0);
    imm = 8'h01;
    issue(1'b1, 3'd1, 3'd5, 3'd7, 3'd0, 3'd0);
    issue(1'b0, 3'd0, 3'd0, 3'd4, 3'd0, 3'd1);
    chk("wrap_data", data, 8'h00);
    chk("wrap_zero", zero, 1'b1);
    issue(1'b0, 3'd0, 3'd0, 3'd5, 3'd1, 3'd0);
    chk("sub_data", data, 8'h02);
    chk("sub_zero", zero, 1'b0);
    issue(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1);
    chk("and", data, 8'h01);
    issue(1'b0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd1);
    chk("or", data, 8'hFF);
    issue(1'b0, 3'd0, 3'd0, 3'd2, 3'd0, 3'd1);
    chk("xor", data, 8'hFE);
    issue(1'b0, 3'd0, 3'd0, 3'd3, 3'd1, 3'd0);
    chk("not", data, 8'hFE);

    // MUL handshake: 13*11 = 143, queued PASS behind it
    imm = 8'd13;
    issue(1'b1, 3'd4, 3'd5, 3'd7, 3'd0, 3'd0);
    imm = 8'd11;
    issue(1'b1, 3'd5, 3'd5, 3'd7, 3'd0, 3'd0);
    chk("pre_mul_data", data, 8'hFF);
    wen = 1'b0; op = 3'd6; ra = 3'd4; rb = 3'd5; instr_valid = 1'b1;
    @(posedge clk); #1;
    op = 3'd7; ra = 3'd4;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("mul_ready_low%0d", i), instr_ready, 1'b0);
      chk($sformatf("mul_dv_low%0d", i), data_valid, 1'b0);
      chk($sformatf("mul_hold%0d", i), data, 8'hFF);
      @(posedge clk); #1;
    end
    chk("mul_data", data, 8'd143);
    chk("mul_dv", data_valid, 1'b1);
    chk("mul_ready", instr_ready, 1'b1);
    @(posedge clk); #1;
    chk("queued_data", data, 8'd13);
    chk("queued_dv", data_valid, 1'b1);
    instr_valid = 1'b0;

    // reset three cycles into a MUL
    issue(1'b0, 3'd0, 3'd0, 3'd6, 3'd4, 3'd5);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_data", data, 8'h00);
    chk("abort_dv", data_valid, 1'b0);
    chk("abort_zero", zero, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_ready", instr_ready, 1'b1);
    pulses = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (data_valid) pulses++;
    end
    chk("abort_no_pulse", pulses, 0);
    issue(1'b0, 3'd0, 3'd0, 3'd4, 3'd4, 3'd5);
    chk("rf_cleared", data, 8'h00);
    chk("rf_cleared_zero", zero, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pe_wide.md
Name: pe_wide

Overview:
- Parametrised successor to the 1-bit processing element: WIDTH-bit datapath, NREGS-entry register file, registered result, and a valid/ready instruction handshake.
- Adds two things the single-bit PE lacks: arithmetic ops (ADD/SUB) and a multi-cycle shift-add multiply.
- Sits in the PE array. Neighbours north/south/east/west are other PEs' `data` outputs; `imm` and instructions come from the array sequencer.

Parameters:
- WIDTH, 8, datapath width in bits (>=2)
- NREGS, 8, register-file entries (power of 2, >=2)
- AW, $clog2(NREGS), register address width (derived, not overridden)

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  asynchronous active-high reset
- instr_valid  in  1  instruction present
- instr_ready  out  1  PE can accept an instruction
- wen  in  1  write mux result into rf[w] on accept
- w  in  AW  write address
- ra  in  AW  operand A address
- rb  in  AW  operand B address
- src  in  3  write-source select
- op  in  3  ALU opcode
- north, south, east, west  in  WIDTH  neighbour data
- imm  in  WIDTH  immediate
- data  out  WIDTH  registered ALU result
- data_valid  out  1  one-cycle pulse: data updated
- zero  out  1  registered, data==0 flag, updated with data

Behaviour:
- Reset (asynchronous, rst=1): all rf entries=0, data=0, data_valid=0, zero=1, state=IDLE, counter=0.
  - An in-flight MUL is aborted; no result is produced.
  - instr_ready=1 in the first cycle after rst deasserts.
- Accept: an instruction is accepted on a rising edge where instr_valid && instr_ready.
  - instr_ready = (state==IDLE), purely from state. It does not depend on instr_valid.
- Source mux:
  - src values: 0 north, 1 south, 2 east, 3 west, 4 data (feedback of the current data register), 5 imm, 6/7 all-zero.
- Register file:
  - On accept with wen=1: rf[w] <= mux value, on the same edge.
  - Reads of rf[ra] and rf[rb] are combinational and see pre-write contents (read-before-write). Operands never observe the same-instruction write.
- Ops (results truncated to WIDTH):
  - 0 AND
  - 1 OR
  - 2 XOR
  - 3 NOT a
  - 4 a+b (mod 2^WIDTH)
  - 5 a-b (mod 2^WIDTH)
  - 6 MUL, low WIDTH bits of a*b, unsigned
  - 7 PASS a
- Single-cycle ops (all except 6):
  - data and zero update on the accept edge.
  - data_valid=1 for exactly the following cycle.
  - Back-to-back accepts give data_valid high continuously, one result per cycle.
- MUL FSM:
  - States: IDLE, MUL.
  - On accept of op 6: latch a and b into multiplicand/multiplier registers, clear the accumulator, counter <= WIDTH-1, state <= MUL, instr_ready falls.
  - Each MUL cycle: if multiplier[0], acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; counter decrements.
  - On the edge where counter==0 in MUL: data <= final acc, zero updated, state <= IDLE.
  - data_valid is high for one cycle after that edge.
  - Latency: accept at edge E, result at edge E+WIDTH. instr_ready is low for WIDTH cycles.
- No accepts occur during MUL, and instr_valid is ignored. Operands are latched, so rf writes cannot corrupt an in-flight multiply.
- data holds its value between results. data_valid=0 whenever no result was produced on the prior edge.

Test Plan:
- Reset mid-MUL (WIDTH=8): accept MUL, assert rst 3 cycles later -> data=0, data_valid=0, zero=1, instr_ready=1 after release; no later data_valid pulse.
- Neighbour write then ADD:
  - Step 1: north=8'h21, src=0, wen=1, w=1 -> rf[1]=8'h21.
  - Step 2: imm=8'h0F, src=5, w=2.
  - Step 3: op=4, ra=1, rb=2.
  - Result -> data=8'h30 with a one-cycle data_valid.
- Read-before-write: rf[3]=8'h05; accept wen=1, w=3, src=5, imm=8'hAA, op=7, ra=3 -> data=8'h05, then rf[3]=8'hAA.
- Wrap/zero: rf[0]=8'hFF, rf[1]=8'h01, op=4 -> data=8'h00, zero=1; op=5 with ra=1, rb=0 -> data=8'h02, zero=0.
- MUL handshake: rf[4]=8'd13, rf[5]=8'd11, op=6, instr_valid held high with a second instruction queued -> instr_ready low for 8 cycles, data=8'd143 at accept+8, data_valid 1 cycle, then the queued instruction is accepted.
- Feedback and streaming: after data=8'h30, three back-to-back accepts of src=4, wen=1, w=6, op=7, ra=6 -> rf[6]=8'h30 after the first accept; data_valid stays high 3 consecutive cycles.
